b_operand_feeder: RTL and testbench



---
 rtl/b_operand_feeder.sv | 168 ++++++++++++++++
 tb/tb_b_operand_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/b_operand_feeder.sv
// Read-side sequencer for the column-major B-operand memory of the 4x4 systolic array.
// Drives skewed per-lane read addresses and a valid mask aligned with the registered read data.
module b_operand_feeder (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] base_addr,
    input  logic [5:0] k_len,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic       mem_r_en,
    output logic [6:0] mem_read_addr_0,
    output logic [6:0] mem_read_addr_1,
    output logic [6:0] mem_read_addr_2,
    output logic [6:0] mem_read_addr_3,
    output logic [3:0] lane_valid
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH
    } state_t;

    // Lane j is active for steps j .. j+k-1, which produces the diagonal skew.
    function automatic logic [3:0] step_mask(input logic [6:0] t, input logic [5:0] k);
        logic [7:0] t8;
        logic [7:0] lo;
        logic [7:0] hi;
        step_mask = '0;
        t8 = {1'b0, t};
        for (int j = 0; j < 4; j++) begin
            lo = 8'(j);
            hi = 8'(j) + {2'b00, k};
            step_mask[j] = (t8 >= lo) && (t8 < hi);
        end
    endfunction

    function automatic logic [6:0] lane_addr(input logic [6:0] base, input logic [5:0] k,
                                             input logic [6:0] t, input int j);
        logic [8:0] col_off;
        col_off = 9'(j) * {3'b000, k};
        lane_addr = base + col_off[6:0] + t - 7'(j);
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       t_q, t_d;
    logic [6:0]       base_q, base_d;
    logic [5:0]       k_q, k_d;
    logic             last_q, last_d;
    logic [3:0]       mask_q, mask_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             r_en_q, r_en_d;
    logic [3:0][6:0]  addr_q, addr_d;
    logic [3:0]       valid_q, valid_d;

    logic             do_issue;
    logic [6:0]       t_cur;
    logic [6:0]       cfg_base;
    logic [5:0]       cfg_k;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise paths that skip it infer latches.
        state_d  = state_q;
        t_d      = t_q;
        base_d   = base_q;
        k_d      = k_q;
        last_d   = last_q;
        mask_d   = '0;
        r_en_d   = 1'b0;
        addr_d   = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        valid_d  = mask_q;
        do_issue = 1'b0;
        t_cur    = t_q;
        cfg_base = base_q;
        cfg_k    = k_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    k_d      = k_len;
                    cfg_base = base_addr;
                    cfg_k    = k_len;
                    t_cur    = '0;
                    t_d      = '0;
                    last_d   = 1'b0;
                    busy_d   = 1'b1;
                    if (k_len == 6'd0) begin
                        state_d = FLUSH;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        do_issue = !stall;
                    end
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                if (last_q) begin
                    state_d = FLUSH;
                    done_d  = 1'b1;
                end else begin
                    do_issue = !stall;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                t_d     = '0;
                last_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs for the next cycle are computed here so every port comes straight from a flop.
        if (do_issue) begin
            r_en_d = 1'b1;
            mask_d = step_mask(t_cur, cfg_k);
            for (int j = 0; j < 4; j++) begin
                addr_d[j] = mask_d[j] ? lane_addr(cfg_base, cfg_k, t_cur, j) : 7'd0;
            end
            last_d = ({1'b0, t_cur} == ({2'b00, cfg_k} + 8'd2));
            t_d    = t_cur + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            base_q  <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_en_q  <= 1'b0;
            addr_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            base_q  <= base_d;
            k_q     <= k_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            r_en_q  <= r_en_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign mem_r_en        = r_en_q;
    assign mem_read_addr_0 = addr_q[0];
    assign mem_read_addr_1 = addr_q[1];
    assign mem_read_addr_2 = addr_q[2];
    assign mem_read_addr_3 = addr_q[3];
    assign lane_valid      = valid_q;

endmodule

// File: tb/tb_b_operand_feeder.sv
// Directed bench for b_operand_feeder: per-cycle expectation tables for each tile pass,
// plus hand-written sequences for reset and back-to-back starts.
module tb_b_operand_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] base_addr;
    logic [5:0] k_len;
    logic       stall;
    logic       busy;
    logic       done;
    logic       mem_r_en;
    logic [6:0] mem_read_addr_0;
    logic [6:0] mem_read_addr_1;
    logic [6:0] mem_read_addr_2;
    logic [6:0] mem_read_addr_3;
    logic [3:0] lane_valid;

    b_operand_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .k_len           (k_len),
        .stall           (stall),
        .busy            (busy),
        .done            (done),
        .mem_r_en        (mem_r_en),
        .mem_read_addr_0 (mem_read_addr_0),
        .mem_read_addr_1 (mem_read_addr_1),
        .mem_read_addr_2 (mem_read_addr_2),
        .mem_read_addr_3 (mem_read_addr_3),
        .lane_valid      (lane_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r_en;
        logic [6:0] a0, a1, a2, a3;
        logic [3:0] v;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tab[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [34:0] dut_vec();
        return {mem_r_en, mem_read_addr_0, mem_read_addr_1, mem_read_addr_2,
                mem_read_addr_3, lane_valid, busy, done};
    endfunction

    function automatic logic [34:0] pack(input vec_t e);
        return {e.r_en, e.a0, e.a1, e.a2, e.a3, e.v, e.busy, e.done};
    endfunction

    task automatic check(input string name, input int cyc, input logic [34:0] got,
                         input logic [34:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h (r_en|a0|a1|a2|a3|valid|busy|done)",
                     name, cyc, got, exp);
        end
    endtask

    task automatic row(input logic r, input int a0, input int a1, input int a2, input int a3,
                       input logic [3:0] v, input logic b, input logic d);
        vec_t e;
        e.r_en = r;
        e.a0 = 7'(a0);
        e.a1 = 7'(a1);
        e.a2 = 7'(a2);
        e.a3 = 7'(a3);
        e.v = v;
        e.busy = b;
        e.done = d;
        tab.push_back(e);
    endtask

    task automatic fill_basic();
        tab.delete();
        row(1, 16,  0,  0,  0, 4'b0000, 1, 0);
        row(1, 17, 20,  0,  0, 4'b0001, 1, 0);
        row(1, 18, 21, 24,  0, 4'b0011, 1, 0);
        row(1, 19, 22, 25, 28, 4'b0111, 1, 0);
        row(1,  0, 23, 26, 29, 4'b1111, 1, 0);
        row(1,  0,  0, 27, 30, 4'b1110, 1, 0);
        row(1,  0,  0,  0, 31, 4'b1100, 1, 0);
        row(0,  0,  0,  0,  0, 4'b1000, 1, 1);
        row(0,  0,  0,  0,  0, 4'b0000, 0, 0);
    endtask

    // Entered at a falling edge with inputs idle; row c of tab is checked in cycle c after accept.
    // stall_cyc names the output cycle to be stalled, so stall is driven one cycle earlier.
    task automatic run_scn(input string name, input logic [6:0] b, input logic [5:0] k,
                           input int stall_cyc, input int poke_cyc, input int rst_cyc);
        base_addr = b;
        k_len     = k;
        start     = 1'b1;
        stall     = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= tab.size(); c++) begin
            @(negedge clk);
            start = 1'b0;
            check(name, c, dut_vec(), pack(tab[c-1]));
            stall = (c + 1 == stall_cyc);
            rst   = (c == rst_cyc);
            if (c == poke_cyc) begin
                start     = 1'b1;
                base_addr = 7'd0;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        base_addr = 7'd16;
        k_len     = 6'd4;
        stall     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 0, dut_vec(), 35'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset_idle", 0, dut_vec(), 35'd0);

        fill_basic();
        run_scn("basic", 7'd16, 6'd4, 0, 0, 0);

        tab.delete();
        row(1, 16,  0,  0,  0, 4'b0000, 1, 0);
        row(1, 17, 20,  0,  0, 4'b0001, 1, 0);
        row(0,  0,  0,  0,  0, 4'b0011, 1, 0);
        row(1, 18, 21, 24,  0, 4'b0000, 1, 0);
        row(1, 19, 22, 25, 28, 4'b0111, 1, 0);
        row(1,  0, 23, 26, 29, 4'b1111, 1, 0);
        row(1,  0,  0, 27, 30, 4'b1110, 1, 0);
        row(1,  0,  0,  0, 31, 4'b1100, 1, 0);
        row(0,  0,  0,  0,  0, 4'b1000, 1, 1);
        row(0,  0,  0,  0,  0, 4'b0000, 0, 0);
        run_scn("stall", 7'd16, 6'd4, 3, 0, 0);

        tab.delete();
        row(1, 120,   0, 0, 0, 4'b0000, 1, 0);
        row(1, 121, 124, 0, 0, 4'b0001, 1, 0);
        row(1, 122, 125, 0, 0, 4'b0011, 1, 0);
        row(1, 123, 126, 1, 4, 4'b0111, 1, 0);
        row(1,   0, 127, 2, 5, 4'b1111, 1, 0);
        row(1,   0,   0, 3, 6, 4'b1110, 1, 0);
        row(1,   0,   0, 0, 7, 4'b1100, 1, 0);
        row(0,   0,   0, 0, 0, 4'b1000, 1, 1);
        row(0,   0,   0, 0, 0, 4'b0000, 0, 0);
        run_scn("wrap", 7'd120, 6'd4, 0, 0, 0);

        tab.delete();
        row(0, 0, 0, 0, 0, 4'b0000, 1, 1);
        row(0, 0, 0, 0, 0, 4'b0000, 0, 0);
        row(0, 0, 0, 0, 0, 4'b0000, 0, 0);
        run_scn("k0", 7'd16, 6'd0, 0, 0, 0);

        tab.delete();
        row(1, 16,  0,  0,  0, 4'b0000, 1, 0);
        row(1,  0, 17,  0,  0, 4'b0001, 1, 0);
        row(1,  0,  0, 18,  0, 4'b0010, 1, 0);
        row(1,  0,  0,  0, 19, 4'b0100, 1, 0);
        row(0,  0,  0,  0,  0, 4'b1000, 1, 1);
        row(0,  0,  0,  0,  0, 4'b0000, 0, 0);
        run_scn("k1", 7'd16, 6'd1, 0, 0, 0);

        // A start sampled mid-pass must not disturb the addresses.
        fill_basic();
        run_scn("start_busy", 7'd16, 6'd4, 0, 3, 0);

        // Start in the IDLE cycle right after FLUSH is accepted and issues next cycle.
        base_addr = 7'd40;
        k_len     = 6'd2;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("restart_issue", 10, dut_vec(), {1'b1, 7'd40, 7'd0, 7'd0, 7'd0, 4'b0000, 1'b1, 1'b0});
        repeat (5) @(negedge clk);
        check("restart_done", 15, dut_vec(), {1'b0, 28'd0, 4'b1000, 1'b1, 1'b1});
        @(negedge clk);
        check("restart_idle", 16, dut_vec(), 35'd0);

        tab.delete();
        row(1, 16,  0,  0,  0, 4'b0000, 1, 0);
        row(1, 17, 20,  0,  0, 4'b0001, 1, 0);
        row(1, 18, 21, 24,  0, 4'b0011, 1, 0);
        row(1, 19, 22, 25, 28, 4'b0111, 1, 0);
        row(0,  0,  0,  0,  0, 4'b0000, 0, 0);
        row(0,  0,  0,  0,  0, 4'b0000, 0, 0);
        run_scn("mid_reset", 7'd16, 6'd4, 0, 0, 4);

        fill_basic();
        run_scn("after_reset", 7'd16, 6'd4, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
